// File: rtl/passthru_pkg.sv
// passthru_pkg: shared defaults and DTR/RTS decode for the ESP32 passthru.
// The decode maps the accepted {ndtr,nrts} pair onto {wifi_en,wifi_gpio0}.
package passthru_pkg;

  localparam int unsigned DEF_TIMEOUT_BITS  = 17;
  localparam int unsigned DEF_FILTER_CYCLES = 2;
  localparam int unsigned DEF_BTN_BITS      = 7;
  localparam int unsigned DEF_PROGN_BITS    = 8;
  localparam logic [6:0]  DEF_PROGN_PATTERN = 7'b0000010;

  typedef enum logic [1:0] {
    PAIR_00 = 2'b00,
    PAIR_01 = 2'b01,
    PAIR_10 = 2'b10,
    PAIR_11 = 2'b11
  } pair_e;

  typedef struct packed {
    logic en;
    logic gpio0;
  } wifi_t;

  localparam wifi_t WIFI_RUN   = '{en: 1'b1, gpio0: 1'b1};
  localparam wifi_t WIFI_HOLD  = '{en: 1'b0, gpio0: 1'b1};
  localparam wifi_t WIFI_BOOT  = '{en: 1'b1, gpio0: 1'b0};

  function automatic wifi_t pair_decode(input logic [1:0] p);
    pair_decode = WIFI_RUN;
    unique case (p)
      PAIR_10: pair_decode = WIFI_HOLD;
      PAIR_01: pair_decode = WIFI_BOOT;
      PAIR_00: pair_decode = WIFI_RUN;
      PAIR_11: pair_decode = WIFI_RUN;
    endcase
  endfunction

endpackage

// File: rtl/sync_filter.sv
// sync_filter: 2-FF synchroniser followed by a stability filter.
// A new value is accepted once seen on C_filter_cycles consecutive clocks.
module sync_filter #(
  parameter int unsigned    W               = 2,
  parameter int unsigned    C_filter_cycles = 2,
  parameter logic [W-1:0]   RST_VAL         = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  localparam int unsigned CW      = $clog2(C_filter_cycles + 1);
  localparam logic [CW:0] RUN_ONE = (CW+1)'(1);
  localparam logic [CW:0] RUN_MAX = (CW+1)'(C_filter_cycles);

  logic [W-1:0]  s1_q, s2_q, prev_q, acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   run;

  // run = length of the current streak of identical samples that differ
  // from the accepted value
  always_comb begin
    acc_d = acc_q;
    cnt_d = '0;
    run   = RUN_ONE;
    if (s2_q != acc_q) begin
      if (s2_q == prev_q) run = {1'b0, cnt_q} + RUN_ONE;
      if (run >= RUN_MAX) acc_d = s2_q;
      else cnt_d = run[CW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      prev_q <= RST_VAL;
      acc_q  <= RST_VAL;
      cnt_q  <= '0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q = acc_q;

endmodule

// File: rtl/passthru_prog_ctrl.sv
// passthru_prog_ctrl: ESP32 enable/boot control from DTR/RTS, programming
// release window, button scan to host and multiboot PROGRAMN request.
module passthru_prog_ctrl
  import passthru_pkg::*;
#(
  parameter int unsigned C_timeout_bits  = DEF_TIMEOUT_BITS,
  parameter int unsigned C_filter_cycles = DEF_FILTER_CYCLES,
  parameter int unsigned C_btn_bits      = DEF_BTN_BITS,
  parameter int unsigned C_progn_bits    = DEF_PROGN_BITS,
  parameter logic [C_btn_bits-1:0] C_progn_pattern =
    C_btn_bits'(DEF_PROGN_PATTERN)
) (
  input  logic                  clk_25mhz,
  input  logic                  rstn,
  input  logic                  ftdi_ndtr,
  input  logic                  ftdi_nrts,
  input  logic [C_btn_bits-1:0] btn,
  input  logic                  spi_clk,
  input  logic                  spi_csn,
  output logic                  wifi_en,
  output logic                  wifi_gpio0,
  output logic                  prog_active,
  output logic                  sd_d0_o,
  output logic                  sd_d0_oe,
  output logic                  user_programn
);

  localparam int unsigned T = C_timeout_bits;
  localparam int unsigned B = C_btn_bits;
  localparam int unsigned P = C_progn_bits;

  localparam logic [T:0]   REL_RST = {1'b1, {T{1'b0}}};
  localparam logic [T:0]   REL_ONE = (T+1)'(1);
  localparam logic [P-1:0] MB_ONE  = P'(1);

  logic [1:0]   pair, pair_prev_q;
  wifi_t        dec;
  logic         trigger, sclk_rise;

  logic [B-1:0] btn_s1_q, btn_s2_q;
  logic         sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic         csn_s1_q, csn_s2_q;

  logic         wifi_en_q, wifi_en_d;
  logic         wifi_gpio0_q, wifi_gpio0_d;
  logic         dec_gpio0_q, dec_gpio0_d;
  logic [T:0]   rel_q, rel_d;
  logic [B:0]   scan_q, scan_d;
  logic [P-1:0] mb_q, mb_d;
  logic         programn_q, programn_d;

  sync_filter #(
    .W               (2),
    .C_filter_cycles (C_filter_cycles),
    .RST_VAL         (2'b11)
  ) u_pair_filt (
    .clk   (clk_25mhz),
    .rst_n (rstn),
    .d     ({ftdi_ndtr, ftdi_nrts}),
    .q     (pair)
  );

  always_comb begin
    dec          = pair_decode(pair);
    wifi_en_d    = dec.en;
    dec_gpio0_d  = dec.gpio0;
    wifi_gpio0_d = dec.gpio0 & btn_s2_q[0];

    trigger = (pair_prev_q == PAIR_11) && (pair == PAIR_10);
    rel_d   = rel_q;
    if (trigger) rel_d = '0;
    else if (!rel_q[T]) rel_d = rel_q + REL_ONE;

    sclk_rise = sclk_s2_q & ~sclk_prev_q;
    scan_d    = scan_q;
    if (csn_s2_q) scan_d = {1'b0, btn_s2_q};
    else if (sclk_rise) scan_d = {scan_q[B-1:0], 1'b0};

    mb_d = '0;
    if (btn_s2_q == C_progn_pattern) mb_d = (&mb_q) ? mb_q : mb_q + MB_ONE;
    programn_d = ~mb_q[P-1];
  end

  always_ff @(posedge clk_25mhz or negedge rstn) begin
    if (!rstn) begin
      btn_s1_q     <= '0;
      btn_s2_q     <= '0;
      sclk_s1_q    <= 1'b1;
      sclk_s2_q    <= 1'b1;
      sclk_prev_q  <= 1'b1;
      csn_s1_q     <= 1'b1;
      csn_s2_q     <= 1'b1;
      pair_prev_q  <= 2'b11;
      wifi_en_q    <= 1'b1;
      wifi_gpio0_q <= 1'b1;
      dec_gpio0_q  <= 1'b1;
      rel_q        <= REL_RST;
      scan_q       <= '0;
      mb_q         <= '0;
      programn_q   <= 1'b1;
    end else begin
      btn_s1_q     <= btn;
      btn_s2_q     <= btn_s1_q;
      sclk_s1_q    <= spi_clk;
      sclk_s2_q    <= sclk_s1_q;
      sclk_prev_q  <= sclk_s2_q;
      csn_s1_q     <= spi_csn;
      csn_s2_q     <= csn_s1_q;
      pair_prev_q  <= pair;
      wifi_en_q    <= wifi_en_d;
      wifi_gpio0_q <= wifi_gpio0_d;
      dec_gpio0_q  <= dec_gpio0_d;
      rel_q        <= rel_d;
      scan_q       <= scan_d;
      mb_q         <= mb_d;
      programn_q   <= programn_d;
    end
  end

  // the release window owns the shared pin; scan readout only when closed
  always_comb begin
    sd_d0_oe = 1'b0;
    sd_d0_o  = 1'b0;
    if (!rel_q[T]) begin
      sd_d0_oe = 1'b1;
      sd_d0_o  = dec_gpio0_q;
    end else if (!csn_s2_q) begin
      sd_d0_oe = 1'b1;
      sd_d0_o  = scan_q[B];
    end
  end

  assign wifi_en       = wifi_en_q;
  assign wifi_gpio0    = wifi_gpio0_q;
  assign prog_active   = ~rel_q[T];
  assign user_programn = programn_q;

endmodule

// File: tb/tb_passthru_prog_ctrl.sv
// tb_passthru_prog_ctrl: decode table, multi-cycle corner sequences and a
// randomized DTR/RTS run against a queue-based reference model.
module tb_passthru_prog_ctrl;

  localparam int TB_T = 4;
  localparam int FILT = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic       ndtr, nrts;
  logic [6:0] btn;
  logic       sclk, csn;
  logic       wifi_en, wifi_gpio0, prog_active;
  logic       sd_d0_o, sd_d0_oe, user_programn;

  int total = 0;
  int bad   = 0;

  always #20 clk = ~clk;

  passthru_prog_ctrl #(.C_timeout_bits(TB_T)) dut (
    .clk_25mhz     (clk),
    .rstn          (rstn),
    .ftdi_ndtr     (ndtr),
    .ftdi_nrts     (nrts),
    .btn           (btn),
    .spi_clk       (sclk),
    .spi_csn       (csn),
    .wifi_en       (wifi_en),
    .wifi_gpio0    (wifi_gpio0),
    .prog_active   (prog_active),
    .sd_d0_o       (sd_d0_o),
    .sd_d0_oe      (sd_d0_oe),
    .user_programn (user_programn)
  );

  typedef struct {
    logic [1:0] pair;
    int         hold;
    logic       en;
    logic       g0;
  } vec_t;

  vec_t tbl[6];

  // reference model state
  logic [1:0] m_pq[$];
  logic       m_bq[$];
  logic [1:0] m_acc, m_accp, m_lastf;
  int         m_run, m_rem;
  logic       m_en, m_g0, m_dg0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic set_pair(input logic [1:0] p);
    {ndtr, nrts} = p;
  endtask

  task automatic wait_rise(input string name);
    int n;
    n = 0;
    while (!prog_active && n < 12) begin
      tick();
      n++;
    end
    check(name, prog_active, 1'b1);
  endtask

  task automatic model_reset();
    m_pq    = '{2'b11, 2'b11};
    m_bq    = '{1'b0, 1'b0};
    m_acc   = 2'b11;
    m_accp  = 2'b11;
    m_lastf = 2'b11;
    m_run   = 0;
    m_rem   = 0;
    m_en    = 1'b1;
    m_g0    = 1'b1;
    m_dg0   = 1'b1;
  endtask

  // one clock edge: inputs reach the logic two clocks late
  task automatic model_edge(input logic [1:0] raw, input logic b0);
    logic [1:0] f;
    logic       bs, trig;
    f  = m_pq.pop_front();
    m_pq.push_back(raw);
    bs = m_bq.pop_front();
    m_bq.push_back(b0);
    case (m_acc)
      2'b10:   begin m_en = 1'b0; m_dg0 = 1'b1; end
      2'b01:   begin m_en = 1'b1; m_dg0 = 1'b0; end
      default: begin m_en = 1'b1; m_dg0 = 1'b1; end
    endcase
    m_g0 = m_dg0 & bs;
    trig = (m_accp == 2'b11) && (m_acc == 2'b10);
    m_accp = m_acc;
    if (trig) m_rem = 1 << TB_T;
    else if (m_rem > 0) m_rem--;
    m_run   = (f == m_lastf) ? m_run + 1 : 1;
    m_lastf = f;
    if (f != m_acc && m_run >= FILT) m_acc = f;
  endtask

  initial begin
    int         cyc, hi, seg, len;
    logic       ok, found;
    logic [7:0] expv;
    logic [1:0] rp;
    logic [1:0] picks [6];

    rstn = 1'b0;
    set_pair(2'b11);
    btn  = 7'b0000001;
    sclk = 1'b0;
    csn  = 1'b1;

    tbl[0] = '{pair: 2'b01, hold: 8, en: 1'b1, g0: 1'b0};
    tbl[1] = '{pair: 2'b00, hold: 8, en: 1'b1, g0: 1'b1};
    tbl[2] = '{pair: 2'b10, hold: 8, en: 1'b0, g0: 1'b1};
    tbl[3] = '{pair: 2'b11, hold: 8, en: 1'b1, g0: 1'b1};
    tbl[4] = '{pair: 2'b01, hold: 8, en: 1'b1, g0: 1'b0};
    tbl[5] = '{pair: 2'b10, hold: 8, en: 1'b0, g0: 1'b1};

    // reset state
    hold(3);
    check("rst_wifi_en", wifi_en, 1'b1);
    check("rst_wifi_gpio0", wifi_gpio0, 1'b1);
    check("rst_prog_active", prog_active, 1'b0);
    check("rst_sd_oe", sd_d0_oe, 1'b0);
    check("rst_sd_o", sd_d0_o, 1'b0);
    check("rst_programn", user_programn, 1'b1);
    rstn = 1'b1;
    hold(4);

    // steady-state decode table
    for (int i = 0; i < 6; i++) begin
      set_pair(tbl[i].pair);
      hold(tbl[i].hold);
      check($sformatf("tbl%0d_en", i), wifi_en, tbl[i].en);
      check($sformatf("tbl%0d_gpio0", i), wifi_gpio0, tbl[i].g0);
    end

    // 11 -> 10 latency, window, then 10 -> 01
    set_pair(2'b11);
    hold(30);
    set_pair(2'b10);
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < 10) begin
      tick();
      cyc++;
      if (!wifi_en) found = 1'b1;
    end
    check("en_drop_latency_ok", found && cyc <= 2 + FILT + 1, 1'b1);
    check("hold_gpio0", wifi_gpio0, 1'b1);
    check("hold_prog_active", prog_active, 1'b1);
    check("hold_sd_oe", sd_d0_oe, 1'b1);
    check("hold_sd_o", sd_d0_o, 1'b1);
    set_pair(2'b01);
    hold(8);
    check("boot_en", wifi_en, 1'b1);
    check("boot_gpio0", wifi_gpio0, 1'b0);
    check("boot_sd_o", sd_d0_o, 1'b0);

    // one-clock ndtr glitch is filtered out
    set_pair(2'b11);
    hold(30);
    set_pair(2'b01);
    tick();
    set_pair(2'b11);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!wifi_en || !wifi_gpio0) ok = 1'b0;
    end
    check("glitch_ignored", ok, 1'b1);

    // window length, single trigger
    check("win_closed_before", prog_active, 1'b0);
    set_pair(2'b10);
    wait_rise("win_rise");
    hi = 1;
    for (int i = 0; i < 40 && prog_active; i++) begin
      tick();
      if (prog_active) hi++;
    end
    check("win_len_16", hi, 16);

    // retrigger landing at count 9 extends the window by 16
    set_pair(2'b11);
    hold(30);
    set_pair(2'b10);
    wait_rise("retrig_rise");
    hi = 1;
    for (int i = 1; i <= 60; i++) begin
      if (i == 3) set_pair(2'b11);
      if (i == 5) set_pair(2'b10);
      tick();
      if (prog_active) hi++;
      else break;
    end
    check("win_len_retrig", hi, 9 + 16);

    // button scan out on the shared pin
    set_pair(2'b11);
    hold(30);
    btn  = 7'b1000101;
    csn  = 1'b1;
    sclk = 1'b0;
    hold(4);
    check("scan_idle_oe", sd_d0_oe, 1'b0);
    csn = 1'b0;
    hold(4);
    check("scan_oe", sd_d0_oe, 1'b1);
    expv = 8'b01000101;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("scan_bit%0d", i), sd_d0_o, expv[7-i]);
      sclk = 1'b1;
      hold(2);
      sclk = 1'b0;
      hold(2);
    end
    csn = 1'b1;
    hold(3);
    check("scan_end_oe", sd_d0_oe, 1'b0);
    check("scan_end_o", sd_d0_o, 1'b0);

    // multiboot hold
    btn = 7'b0000010;
    hold(120);
    check("mb_not_yet", user_programn, 1'b1);
    hold(20);
    check("mb_asserted", user_programn, 1'b0);
    btn = 7'b0000001;
    hold(5);
    check("mb_released", user_programn, 1'b1);
    btn = 7'b0000010;
    ok = 1'b1;
    for (int i = 0; i < 201; i++) begin
      btn = (i == 100) ? 7'b0000011 : 7'b0000010;
      tick();
      if (!user_programn) ok = 1'b0;
    end
    check("mb_mismatch_holds", ok, 1'b1);
    btn = 7'b0000001;
    hold(5);

    // reset in the middle of a window
    set_pair(2'b11);
    hold(30);
    set_pair(2'b10);
    wait_rise("rst_win_rise");
    hold(3);
    check("rst_win_open", prog_active, 1'b1);
    #2;
    rstn = 1'b0;
    set_pair(2'b11);
    #1;
    check("arst_wifi_en", wifi_en, 1'b1);
    check("arst_wifi_gpio0", wifi_gpio0, 1'b1);
    check("arst_prog_active", prog_active, 1'b0);
    check("arst_sd_oe", sd_d0_oe, 1'b0);
    check("arst_sd_o", sd_d0_o, 1'b0);
    check("arst_programn", user_programn, 1'b1);
    hold(2);
    rstn = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (prog_active || !wifi_en) ok = 1'b0;
    end
    check("post_rst_quiet", ok, 1'b1);

    // randomized DTR/RTS against the reference model
    rstn = 1'b0;
    set_pair(2'b11);
    btn  = 7'b0000001;
    csn  = 1'b1;
    sclk = 1'b0;
    hold(2);
    rstn = 1'b1;
    model_reset();
    picks = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00};
    for (seg = 0; seg < 120; seg++) begin
      rp  = picks[$urandom_range(0, 5)];
      len = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(1, 5));
      set_pair(rp);
      btn = {6'b0, 1'($urandom_range(0, 1))};
      for (int k = 0; k < len; k++) begin
        @(posedge clk);
        model_edge({ndtr, nrts}, btn[0]);
        #1;
        check("rnd_en", wifi_en, m_en);
        check("rnd_gpio0", wifi_gpio0, m_g0);
        check("rnd_prog", prog_active, m_rem > 0);
        check("rnd_oe", sd_d0_oe, m_rem > 0);
        check("rnd_o", sd_d0_o, (m_rem > 0) ? m_dg0 : 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
